// File: rtl/mc_control_v2.sv
// Multi-cycle MIPS control FSM: Moore decode of the current state, with branch
// resolution folded into pc_en, a memory handshake, HALT/ILLEGAL trapping and a retire counter.
module mc_control_v2 #(
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcB,
  output logic             ext_zero,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [4:0]       beat,
  output logic [3:0]       state_out,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR  = 4'd2,  MEMRD = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC   = 4'd6,  RWB   = 4'd7;
  localparam logic [3:0] IEXEC  = 4'd8,  IWB    = 4'd9,  BRANCH  = 4'd10, JUMP  = 4'd11;
  localparam logic [3:0] JAL    = 4'd12, JR     = 4'd13, HALT    = 4'd14, ILLEGAL = 4'd15;

  logic [3:0]       state_r, next_s;
  logic             illegal_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_s;
  logic             pc_en_s, irwrite_s, regwrite_s, memwrite_s;

  assign ready_s = MEM_WAIT ? mem_ready : 1'b1;

  // Next-state selection; IR-driven paths are resolved in DECODE
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH:   next_s = ready_s ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          6'b000000: next_s = (funct == 6'b001000) ? JR : REXEC;
          6'b100011, 6'b101011: next_s = MEMADR;
          6'b000100, 6'b000101: next_s = BRANCH;
          6'b000010: next_s = JUMP;
          6'b000011: next_s = JAL;
          6'b001000, 6'b001100, 6'b001101, 6'b001010: next_s = IEXEC;
          6'b111111: next_s = HALT;
          default:   next_s = ILLEGAL;
        endcase
      end
      MEMADR:  next_s = (opcode == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:   next_s = ready_s ? MEMWB : MEMRD;
      MEMWR:   next_s = ready_s ? FETCH : MEMWR;
      REXEC:   next_s = RWB;
      IEXEC:   next_s = IWB;
      HALT:    next_s = HALT;
      default: next_s = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= FETCH;
    else     state_r <= next_s;
  end

  // Sticky illegal flag, raised as the FSM enters ILLEGAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          illegal_r <= 1'b0;
    else if (state_r == DECODE && next_s == ILLEGAL)  illegal_r <= 1'b1;
    else                                              illegal_r <= illegal_r;
  end

  // Saturating count of committed fetches
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_r <= {CNT_W{1'b0}};
    else if (state_r == FETCH && ready_s && cnt_r != {CNT_W{1'b1}})
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else
      cnt_r <= cnt_r;
  end

  // Moore output decode of the current state
  always_comb begin
    pc_en_s = 1'b0; irwrite_s = 1'b0; regwrite_s = 1'b0; memwrite_s = 1'b0;
    MemRead = 1'b0; IorD = 1'b0; ALUSrcA = 1'b0; ext_zero = 1'b0; halted = 1'b0;
    RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00;
    ALUOp = 3'b000; beat = 5'b00000;
    case (state_r)
      FETCH: begin
        beat = 5'b00001; MemRead = 1'b1; ALUSrcB = 2'b01;
        irwrite_s = ready_s; pc_en_s = ready_s;
      end
      DECODE: begin beat = 5'b00010; ALUSrcB = 2'b11; end
      MEMADR: begin beat = 5'b00100; ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      MEMRD:  begin beat = 5'b01000; IorD = 1'b1; MemRead = 1'b1; end
      MEMWB:  begin beat = 5'b10000; regwrite_s = 1'b1; MemtoReg = 2'b01; end
      MEMWR:  begin beat = 5'b01000; IorD = 1'b1; memwrite_s = 1'b1; end
      REXEC:  begin beat = 5'b00100; ALUSrcA = 1'b1; ALUOp = 3'b010; end
      RWB:    begin beat = 5'b01000; regwrite_s = 1'b1; RegDst = 2'b01; end
      IEXEC: begin
        beat = 5'b00100; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        case (opcode)
          6'b001100: begin ALUOp = 3'b011; ext_zero = 1'b1; end
          6'b001101: begin ALUOp = 3'b100; ext_zero = 1'b1; end
          6'b001010: ALUOp = 3'b101;
          default:   ALUOp = 3'b000;
        endcase
      end
      IWB:    begin beat = 5'b01000; regwrite_s = 1'b1; end
      BRANCH: begin
        beat = 5'b00100; ALUSrcA = 1'b1; ALUOp = 3'b001; PCSource = 2'b01;
        // opcode[0] separates BNE (000101) from BEQ (000100)
        pc_en_s = opcode[0] ? ~zero : zero;
      end
      JUMP:   begin beat = 5'b00100; pc_en_s = 1'b1; PCSource = 2'b10; end
      JAL: begin
        beat = 5'b00100; pc_en_s = 1'b1; PCSource = 2'b10;
        regwrite_s = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10;
      end
      JR:     begin beat = 5'b00100; pc_en_s = 1'b1; PCSource = 2'b11; end
      HALT:   halted = 1'b1;
      default: begin end
    endcase
  end

  // Write/load strobes are blocked for as long as reset is held
  assign pc_en       = pc_en_s    & ~rst;
  assign IRWrite     = irwrite_s  & ~rst;
  assign RegWrite    = regwrite_s & ~rst;
  assign MemWrite    = memwrite_s & ~rst;
  assign state_out   = state_r;
  assign illegal     = illegal_r;
  assign instr_count = cnt_r;

endmodule

// File: tb/tb_mc_control_v2.sv
// Randomized bench: each instruction is expanded into its expected state path,
// and every cycle is checked against the control values listed per state.
module tb_mc_control_v2;
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_en, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcA, ext_zero, halted, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [4:0] beat;
  logic [3:0] state_out, instr_count;

  int vectors = 0, miscompares = 0;
  int exp_cnt = 0;
  logic exp_ill = 1'b0;

  typedef struct { int st; logic mr; } step_t;

  mc_control_v2 #(.CNT_W(4), .MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .ext_zero(ext_zero), .ALUOp(ALUOp), .PCSource(PCSource), .beat(beat),
    .state_out(state_out), .halted(halted), .illegal(illegal), .instr_count(instr_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
      6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  endfunction

  // Control word the spec lists for state st: {pc_en,IRWrite,MemRead,MemWrite,IorD,RegWrite,
  // ALUSrcA,RegDst,MemtoReg,ALUSrcB,ext_zero,ALUOp,PCSource,beat,halted}
  function automatic logic [24:0] ctrl(input int st, input logic [5:0] op, input logic z, input logic mr);
    logic pc, irw, mrd, mwr, iord, rw, sa, ez, h;
    logic [1:0] rd, m2r, sb, pcs;
    logic [2:0] aop;
    logic [4:0] bt;
    {pc, irw, mrd, mwr, iord, rw, sa, ez, h} = 9'd0;
    {rd, m2r, sb, pcs} = 8'd0; aop = 3'd0; bt = 5'd0;
    case (st)
      0:  begin bt = 5'd1;  mrd = 1'b1; sb = 2'b01; irw = mr; pc = mr; end
      1:  begin bt = 5'd2;  sb = 2'b11; end
      2:  begin bt = 5'd4;  sa = 1'b1; sb = 2'b10; end
      3:  begin bt = 5'd8;  iord = 1'b1; mrd = 1'b1; end
      4:  begin bt = 5'd16; rw = 1'b1; m2r = 2'b01; end
      5:  begin bt = 5'd8;  iord = 1'b1; mwr = 1'b1; end
      6:  begin bt = 5'd4;  sa = 1'b1; aop = 3'b010; end
      7:  begin bt = 5'd8;  rw = 1'b1; rd = 2'b01; end
      8:  begin
        bt = 5'd4; sa = 1'b1; sb = 2'b10;
        if (op == 6'h0C) begin aop = 3'b011; ez = 1'b1; end
        else if (op == 6'h0D) begin aop = 3'b100; ez = 1'b1; end
        else if (op == 6'h0A) aop = 3'b101;
        else aop = 3'b000;
      end
      9:  begin bt = 5'd8;  rw = 1'b1; end
      10: begin bt = 5'd4;  sa = 1'b1; aop = 3'b001; pcs = 2'b01; pc = (op == 6'h05) ? ~z : z; end
      11: begin bt = 5'd4;  pc = 1'b1; pcs = 2'b10; end
      12: begin bt = 5'd4;  pc = 1'b1; pcs = 2'b10; rw = 1'b1; rd = 2'b10; m2r = 2'b10; end
      13: begin bt = 5'd4;  pc = 1'b1; pcs = 2'b11; end
      14: h = 1'b1;
      default: begin end
    endcase
    ctrl = {pc, irw, mrd, mwr, iord, rw, sa, rd, m2r, sb, ez, aop, pcs, bt, h};
  endfunction

  task automatic reset_and_check();
    rst = 1'b1; mem_ready = 1'b1;
    #2;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_strobes", {28'd0, pc_en, IRWrite, RegWrite, MemWrite}, 32'd0);
    check("rst_flags", {30'd0, illegal, halted}, 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    exp_cnt = 0; exp_ill = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // fw/mw: mem_ready-low cycles in FETCH / memory step; zf: 0,1 forced zero, else random;
  // abort: step index at which rst is pulsed (-1 = none)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int zf, input int abort);
    step_t q[$];
    for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    case (op)
      6'h00: if (fn == 6'b001000) q.push_back('{13, 1'b1});
             else begin q.push_back('{6, 1'b1}); q.push_back('{7, 1'b0}); end
      6'h23: begin
        q.push_back('{2, 1'b0});
        for (int i = 0; i < mw; i++) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1}); q.push_back('{4, 1'($urandom)});
      end
      6'h2B: begin
        q.push_back('{2, 1'b0});
        for (int i = 0; i < mw; i++) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end
      6'h04, 6'h05: q.push_back('{10, 1'($urandom)});
      6'h02: q.push_back('{11, 1'($urandom)});
      6'h03: q.push_back('{12, 1'($urandom)});
      6'h08, 6'h0C, 6'h0D, 6'h0A: begin q.push_back('{8, 1'b1}); q.push_back('{9, 1'b1}); end
      6'h3F: for (int i = 0; i < 100; i++) q.push_back('{14, 1'($urandom)});
      default: q.push_back('{15, 1'($urandom)});
    endcase
    opcode = op; funct = fn;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].mr;
      zero = (zf == 0 || zf == 1) ? 1'(zf) : 1'($urandom);
      if (i == abort) begin
        rst = 1'b1; #1;
        check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        reset_and_check();
        return;
      end
      #2;
      check("state", 32'(state_out), 32'(q[i].st));
      check("ctrl", {7'd0, pc_en, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcA, RegDst,
                     MemtoReg, ALUSrcB, ext_zero, ALUOp, PCSource, beat, halted},
            {7'd0, ctrl(q[i].st, op, zero, mem_ready)});
      check("instr_count", 32'(instr_count), 32'(exp_cnt));
      check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
      @(posedge clk); #1;
      if (q[i].st == 0 && q[i].mr) exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      if (q[i].st == 1 && !legal_op(op)) exp_ill = 1'b1;
    end
  endtask

  initial begin
    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                             6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    logic [5:0] op, fn;
    #1;
    reset_and_check();
    run_instr(6'h23, 6'd0, 0, 0, 2, -1);          // LW, no waits
    run_instr(6'h2B, 6'd0, 1, 3, 2, -1);          // SW, 3 wait cycles
    run_instr(6'h04, 6'd0, 0, 0, 1, -1);          // BEQ taken
    run_instr(6'h05, 6'd0, 0, 0, 1, -1);          // BNE not taken
    run_instr(6'h03, 6'd0, 0, 0, 2, -1);          // JAL
    run_instr(6'h00, 6'b001000, 0, 0, 2, -1);     // JR
    run_instr(6'b010001, 6'd0, 0, 0, 2, -1);      // illegal opcode
    run_instr(6'h20, 6'd0, 2, 0, 2, -1);          // another illegal, flag stays set
    run_instr(6'h2B, 6'd0, 0, 3, 2, 5);           // SW aborted by rst mid-wait
    for (int i = 0; i < 20; i++) run_instr(6'h08, 6'd0, 0, 0, 2, -1);
    run_instr(6'h0C, 6'd0, 0, 0, 2, -1);          // ANDI
    reset_and_check();
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 12);
      if (k == 12) begin
        do op = 6'($urandom); while (legal_op(op));
      end else op = ops[k];
      fn = 6'($urandom);
      if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'b001000;
      if (op == 6'h00 && k == 0 && fn == 6'b001000) fn = 6'b100000;
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 2, -1);
    end
    run_instr(6'h3F, 6'd0, 0, 0, 2, -1);          // HALT held for 100 cycles
    reset_and_check();
    run_instr(6'h0D, 6'd0, 0, 0, 2, -1);          // ORI after restart
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
